// File: rtl/dram_burst_arbiter.sv
// Round-robin arbiter granting whole DRAM bursts to NUM_REQ requesters in front of dram.sv.
// Optional watchdog and burst-length checking are enabled by defining ARB_WATCHDOG_EN.
module dram_burst_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          beat_valid,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           rdata_out,
    output logic                        err,
    output logic [ADDR_W-1:0]           addr,
    output logic                        read_en,
    output logic                        write_en,
    output logic [DATA_W-1:0]           wdata,
    input  logic                        dram_ready,
    input  logic                        dram_complete,
    input  logic [DATA_W-1:0]           rdata,
    input  logic                        valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BURST} state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]   r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic               r_we, w_we_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    int unsigned        w_cand;
    logic [IDX_W-1:0]   w_rr_after;
    logic               w_wd_expire;
    logic               w_len_err;

    // First set request at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = 0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            w_cand = (int'(r_rr_ptr) + i) % NREQ_U;
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_rr_after = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd_cnt;

    // Cleared while idle, so it starts from zero on the first ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) r_wd_cnt <= '0;
        else                          r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end

    assign w_wd_expire = (r_state != S_IDLE) && (r_wd_cnt == WD_W'(TIMEOUT - 1));
    assign w_len_err   = ((CNT_W+1)'(r_beat_cnt) + (CNT_W+1)'(valid)) != (CNT_W+1)'(BURST_LEN);
`else
    // Without the watchdog TIMEOUT has no effect; the comparison is constant false.
    assign w_wd_expire = (TIMEOUT < 0);
    assign w_len_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gidx     <= w_gidx_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_addr     <= w_addr_nxt;
            r_we       <= w_we_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
        w_beat_nxt  = r_beat_cnt;
        beat_valid  = '0;
        done        = '0;
        rdata_out   = '0;
        err         = 1'b0;
        read_en     = 1'b0;
        write_en    = 1'b0;
        wdata       = '0;

        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt         = '0;
                    w_gnt_nxt[w_pick] = 1'b1;
                    w_gidx_nxt        = w_pick;
                    w_addr_nxt        = req_addr[w_pick*ADDR_W +: ADDR_W];
                    w_we_nxt          = req_we[w_pick];
                    w_state_nxt       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_wd_expire) begin
                    done = r_gnt;
                    err  = 1'b1;
                end else begin
                    read_en  = ~r_we;
                    write_en = r_we;
                    if (dram_ready) w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                beat_valid = valid ? r_gnt : '0;
                rdata_out  = rdata;
                wdata      = req_wdata[r_gidx*DATA_W +: DATA_W];
                if (valid) w_beat_nxt = r_beat_cnt + CNT_W'(1);
                if (dram_complete) begin
                    done = r_gnt;
                    err  = w_len_err;
                end else if (w_wd_expire) begin
                    done = r_gnt;
                    err  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Any burst termination (complete or watchdog) releases the grant.
        if (done != '0) begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_beat_nxt  = '0;
            w_addr_nxt  = '0;
            w_we_nxt    = 1'b0;
            w_rr_nxt    = w_rr_after;
        end
    end

    assign gnt  = r_gnt;
    assign addr = r_addr;

endmodule
